// File: rtl/burst_mac.sv
`default_nettype none
// ============================================================================
// Module   : burst_mac
// Brief    : Fetches a LEN-word burst of packed multi-lane data from a
//            synchronous memory and accumulates every lane in parallel.
// Revision : 1.0 - initial release
// ============================================================================
module burst_mac #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int ADDR_W = 4,
    parameter int LEN    = 16,
    parameter int ACC_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rd,
    input  logic                      act,
    output logic                      mem_re,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [LANES*DATA_W-1:0]   mem_rdata,
    output logic                      done,
    output logic                      busy,
    output logic [LANES*ACC_W-1:0]    sum,
    output logic                      sum_valid
);

    // One extra bit so the word counter can hold LEN == 2**ADDR_W.
    localparam int                c_CNT_W = ADDR_W + 1;
    localparam logic [c_CNT_W-1:0] c_LEN  = c_CNT_W'(LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_rvalid;
    logic                r_done;
    logic                r_sum_valid;
    logic                w_mem_re;
    logic                w_start;

    assign w_mem_re  = (r_state == S_FETCH) && rd && act;
    assign w_start   = (r_state == S_IDLE) && rd;

    assign mem_re    = w_mem_re;
    assign mem_addr  = r_addr;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign sum_valid = r_sum_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_rvalid    <= 1'b0;
            r_done      <= 1'b0;
            r_sum_valid <= 1'b0;
        end else begin
            r_rvalid <= w_mem_re;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rd) begin
                        r_state     <= S_FETCH;
                        r_addr      <= '0;
                        r_cnt       <= '0;
                        r_sum_valid <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (w_mem_re) begin
                        r_addr <= r_addr + ADDR_W'(1);
                        r_cnt  <= r_cnt + c_CNT_W'(1);
                        if (r_cnt + c_CNT_W'(1) == c_LEN) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Last word lands this cycle; result is final on exit.
                    r_state     <= S_DONE;
                    r_done      <= 1'b1;
                    r_sum_valid <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [ACC_W-1:0] r_acc;

        always_ff @(posedge clk) begin
            if (reset || w_start) begin
                r_acc <= '0;
            end else if (r_rvalid) begin
                r_acc <= r_acc + ACC_W'(mem_rdata[gi*DATA_W +: DATA_W]);
            end
        end

        assign sum[gi*ACC_W +: ACC_W] = r_acc;
    end

endmodule
`default_nettype wire

// File: tb/tb_burst_mac.sv
`default_nettype none
// Bench for burst_mac: instance 0 is LEN=16/ACC_W=16, instance 1 is
// LEN=4/ACC_W=8; a cycle-level reference tracks reads, stalls and lane sums.
module tb_burst_mac;

    localparam int AW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  rd_v = 2'b00;
    logic [1:0]  act_v = 2'b00;
    logic [1:0]  re_w, done_w, busy_w, sv_w;
    logic [AW-1:0] addr_a, addr_b;
    logic [31:0] rdata_a = '0, rdata_b = '0;
    logic [63:0] sum_a;
    logic [31:0] sum_b;
    logic [31:0] mem_m [2][16];

    int total = 0;
    int bad = 0;
    int last_cyc = 0;
    bit [1:0] prev_valid = 2'b00;

    always #5 clk = ~clk;

    burst_mac #(.DATA_W(8), .LANES(4), .ADDR_W(AW), .LEN(16), .ACC_W(16)) u_dut_a (
        .clk(clk), .reset(reset), .rd(rd_v[0]), .act(act_v[0]),
        .mem_re(re_w[0]), .mem_addr(addr_a), .mem_rdata(rdata_a),
        .done(done_w[0]), .busy(busy_w[0]), .sum(sum_a), .sum_valid(sv_w[0])
    );

    burst_mac #(.DATA_W(8), .LANES(4), .ADDR_W(AW), .LEN(4), .ACC_W(8)) u_dut_b (
        .clk(clk), .reset(reset), .rd(rd_v[1]), .act(act_v[1]),
        .mem_re(re_w[1]), .mem_addr(addr_b), .mem_rdata(rdata_b),
        .done(done_w[1]), .busy(busy_w[1]), .sum(sum_b), .sum_valid(sv_w[1])
    );

    // Synchronous memories: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (re_w[0]) rdata_a <= mem_m[0][addr_a];
        if (re_w[1]) rdata_b <= mem_m[1][addr_b];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lane_sum(input int sel, input int i);
        if (sel == 1) return 32'(sum_b[i*8 +: 8]);
        return 32'(sum_a[i*16 +: 16]);
    endfunction

    function automatic logic [31:0] get_addr(input int sel);
        if (sel == 1) return 32'(addr_b);
        return 32'(addr_a);
    endfunction

    task automatic fill_random(input int sel);
        for (int k = 0; k < 16; k++) mem_m[sel][k] = $urandom;
    endtask

    // One burst from the IDLE cycle (cycle 0) through the done cycle.
    task automatic run_burst(input int sel, input int pause_at, input int pause_len,
                             input bit rnd_act, input bit hold_rd);
        int len = (sel == 1) ? 4 : 16;
        int mask = (sel == 1) ? 'hFF : 'hFFFF;
        int exp_sum[4];
        int reads = 0;
        int stalls = 0;
        int cyc = 0;
        int pause_left = pause_len;
        bit drained = 0;
        bit fin = 0;

        for (int i = 0; i < 4; i++) begin
            exp_sum[i] = 0;
            for (int k = 0; k < len; k++) exp_sum[i] += (mem_m[sel][k] >> (8*i)) & 'hFF;
            exp_sum[i] &= mask;
        end

        @(negedge clk);
        rd_v[sel] = 1'b1;
        act_v[sel] = 1'b0;
        #1;
        chk("idle_busy", 32'(busy_w[sel]), 0);
        chk("idle_sum_valid", 32'(sv_w[sel]), 32'(prev_valid[sel]));

        while (!fin) begin
            @(negedge clk);
            cyc++;
            if (reads < len) begin
                if (pause_left > 0 && reads == pause_at) begin
                    act_v[sel] = 1'b0;
                    pause_left--;
                end else if (rnd_act) begin
                    act_v[sel] = ($urandom_range(0, 3) != 0);
                end else begin
                    act_v[sel] = 1'b1;
                end
            end
            #1;
            if (cyc == 1) begin
                chk("start_clear", lane_sum(sel,0) | lane_sum(sel,1) | lane_sum(sel,2) | lane_sum(sel,3), 0);
                chk("start_sum_valid", 32'(sv_w[sel]), 0);
            end
            if (reads < len) begin
                chk("fetch_re", 32'(re_w[sel]), 32'(act_v[sel]));
                chk("fetch_addr", get_addr(sel), 32'(reads % 16));
                chk("fetch_busy", 32'(busy_w[sel]), 1);
                chk("fetch_done", 32'(done_w[sel]), 0);
                if (act_v[sel]) reads++;
                else stalls++;
            end else if (!drained) begin
                chk("drain_re", 32'(re_w[sel]), 0);
                chk("drain_busy", 32'(busy_w[sel]), 1);
                chk("drain_done", 32'(done_w[sel]), 0);
                chk("drain_addr", get_addr(sel), 32'(reads % 16));
                drained = 1;
            end else begin
                chk("done_pulse", 32'(done_w[sel]), 1);
                chk("done_sum_valid", 32'(sv_w[sel]), 1);
                chk("done_re", 32'(re_w[sel]), 0);
                chk("done_cycle", 32'(cyc), 32'(len + 2 + stalls));
                for (int i = 0; i < 4; i++) chk("done_lane_sum", lane_sum(sel, i), 32'(exp_sum[i]));
                fin = 1;
            end
            if (!fin && cyc > 300) begin
                chk("timeout_cycle", 32'(cyc), 32'(len + 2 + stalls));
                fin = 1;
            end
        end
        last_cyc = cyc;
        prev_valid[sel] = 1'b1;

        if (!hold_rd) begin
            @(negedge clk);
            rd_v[sel] = 1'b0;
            act_v[sel] = 1'b0;
            #1;
            chk("post_busy", 32'(busy_w[sel]), 0);
            chk("post_done", 32'(done_w[sel]), 0);
            chk("post_sum_valid", 32'(sv_w[sel]), 1);
            chk("post_lane0_hold", lane_sum(sel, 0), 32'(exp_sum[0]));
        end
    endtask

    initial begin
        int ndone;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("rst_busy", 32'(busy_w[s]), 0);
            chk("rst_done", 32'(done_w[s]), 0);
            chk("rst_sum_valid", 32'(sv_w[s]), 0);
            chk("rst_re", 32'(re_w[s]), 0);
            chk("rst_addr", get_addr(s), 0);
            for (int i = 0; i < 4; i++) chk("rst_sum", lane_sum(s, i), 0);
        end

        // Basic burst: word k carries k+1 in every lane, sum 10 per lane.
        for (int k = 0; k < 16; k++) mem_m[1][k] = {4{8'(k + 1)}};
        run_burst(1, -1, 0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) chk("basic_lane", lane_sum(1, i), 10);

        // Pause: act low 3 cycles after the 2nd read.
        run_burst(1, 2, 3, 1'b0, 1'b0);
        chk("pause_done_cycle", 32'(last_cyc), 9);
        for (int i = 0; i < 4; i++) chk("pause_lane", lane_sum(1, i), 10);

        // Lane independence and 8-bit wrap.
        for (int k = 0; k < 16; k++) mem_m[1][k] = 32'h0100_00FF;
        run_burst(1, -1, 0, 1'b0, 1'b0);
        chk("wrap_lane0", lane_sum(1, 0), 'hFC);
        chk("wrap_lane1", lane_sum(1, 1), 0);
        chk("wrap_lane2", lane_sum(1, 2), 0);
        chk("wrap_lane3", lane_sum(1, 3), 'h04);

        // Full address range on the 16-deep instance.
        fill_random(0);
        run_burst(0, -1, 0, 1'b0, 1'b0);
        chk("full_done_cycle", 32'(last_cyc), 18);

        // Reset during the 3rd read cycle.
        @(negedge clk);
        rd_v[0] = 1'b1;
        act_v[0] = 1'b1;
        repeat (2) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_re", 32'(re_w[0]), 1);
        @(negedge clk);
        reset = 1'b0;
        rd_v[0] = 1'b0;
        act_v[0] = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy_w[0]), 0);
        chk("rst_mid_sum_valid", 32'(sv_w[0]), 0);
        chk("rst_mid_sum_lo", sum_a[31:0], 0);
        chk("rst_mid_sum_hi", sum_a[63:32], 0);
        chk("rst_mid_addr", get_addr(0), 0);
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (done_w[0]) ndone++;
        end
        chk("rst_mid_no_done", 32'(ndone), 0);
        prev_valid = 2'b00;
        fill_random(0);
        run_burst(0, -1, 0, 1'b0, 1'b0);

        // Back-to-back with rd held high through DONE.
        fill_random(0);
        run_burst(0, -1, 0, 1'b1, 1'b1);
        fill_random(0);
        run_burst(0, -1, 0, 1'b1, 1'b0);

        // Randomized bursts with random act drops.
        for (int n = 0; n < 10; n++) begin
            int sel;
            sel = $urandom_range(0, 1);
            fill_random(sel);
            run_burst(sel, -1, 0, 1'b1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
